// File: rtl/display_scan_ctrl_if.sv
// Display-side bundle between the scan controller, the digit-code selector and the panel.
// master is the scan controller; slave is the selector/panel side.
interface display_scan_ctrl_if;
    logic [39:0] dig;
    logic [7:0]  en_mask;
    logic [7:0]  blink_mask;
    logic [2:0]  num;
    logic [39:0] dig_lat;
    logic [4:0]  code;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    modport master (
        input  dig, en_mask, blink_mask, code,
        output num, dig_lat, an, seg, frame_tick
    );

    modport slave (
        output dig, en_mask, blink_mask, code,
        input  num, dig_lat, an, seg, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame latch, blanking dead time and blink.
// Latency: an tracks the current slot with no lag; seg = decode(code) one cycle later.
// Backpressure: none; free-running scan, masks sampled live.
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_ctrl_if.master  bus
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_LIM  = DW'(BLANK_CYC);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [DW-1:0] div_cnt, div_nx;
    logic [2:0]    num_q, num_nx;
    logic [FW-1:0] frame_cnt, frame_cnt_nx;
    logic          blink_ph, blink_nx;
    logic [39:0]   dig_lat_q;
    logic [7:0]    an_q, an_nx;
    logic [7:0]    seg_q, seg_nx;
    logic          frame_tick_q;
    logic          slot_end, frame_end;

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (num_q == 3'd7);

    always_comb begin
        div_nx       = slot_end ? '0 : div_cnt + 1'b1;
        num_nx       = slot_end ? num_q + 3'd1 : num_q;
        frame_cnt_nx = frame_cnt;
        blink_nx     = blink_ph;
        if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt_nx = '0;
                blink_nx     = ~blink_ph;
            end else begin
                frame_cnt_nx = frame_cnt + 1'b1;
            end
        end
    end

    // Anodes come from next-state slot values so the registered an lines up with div_cnt/num.
    always_comb begin
        an_nx = 8'hFF;
        if ((div_nx >= BLANK_LIM) && bus.en_mask[num_nx] &&
            !(blink_nx && bus.blink_mask[num_nx])) begin
            an_nx[num_nx] = 1'b0;
        end
    end

    always_comb begin
        seg_nx = 8'hFF;
        case (bus.code)
            5'h00:   seg_nx = 8'hC0;
            5'h01:   seg_nx = 8'hF9;
            5'h02:   seg_nx = 8'hA4;
            5'h03:   seg_nx = 8'hB0;
            5'h04:   seg_nx = 8'h99;
            5'h05:   seg_nx = 8'h92;
            5'h06:   seg_nx = 8'h82;
            5'h07:   seg_nx = 8'hF8;
            5'h08:   seg_nx = 8'h80;
            5'h09:   seg_nx = 8'h90;
            5'h0A:   seg_nx = 8'h88;
            5'h0B:   seg_nx = 8'h83;
            5'h0C:   seg_nx = 8'hC6;
            5'h0D:   seg_nx = 8'hA1;
            5'h0E:   seg_nx = 8'h86;
            5'h0F:   seg_nx = 8'h8E;
            5'h11:   seg_nx = 8'hBF;
            default: seg_nx = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            num_q        <= 3'd0;
            frame_cnt    <= '0;
            blink_ph     <= 1'b0;
            dig_lat_q    <= 40'd0;
            an_q         <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt      <= div_nx;
            num_q        <= num_nx;
            frame_cnt    <= frame_cnt_nx;
            blink_ph     <= blink_nx;
            an_q         <= an_nx;
            seg_q        <= seg_nx;
            frame_tick_q <= frame_end;
            if (frame_end) begin
                dig_lat_q <= bus.dig;
            end
        end
    end

    assign bus.num        = num_q;
    assign bus.dig_lat    = dig_lat_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_display_scan_ctrl;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BF = 2;

    typedef struct {
        string       name;
        bit          c_an;
        logic [7:0]  an;
        bit          c_seg;
        logic [7:0]  seg;
        bit          c_num;
        logic [2:0]  num;
        bit          c_lat;
        logic [39:0] lat;
        bit          c_ft;
        logic        ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scan_ctrl_if ifc();

    display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    // Selector stand-in: either follows the latched frame or is driven directly.
    logic       sel_mode;
    logic [4:0] code_drv;
    assign ifc.code = sel_mode ? ifc.dig_lat[5*ifc.num +: 5] : code_drv;

    int          checks = 0;
    int          errors = 0;
    int          tc;
    bit          inv_en = 1'b0;
    logic [39:0] exp_lat;
    logic [4:0]  prev_code;
    string       phase;
    exp_t        q[$];
    exp_t        mon_e;

    logic [4:0] sweep_code [19] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                    5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F,
                                    5'h10, 5'h11, 5'h1F};
    logic [7:0] sweep_seg [19] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
                                   8'hFF, 8'hBF, 8'hFF};

    function automatic logic [7:0] dec(input logic [4:0] c);
        logic [7:0] r;
        r = 8'hFF;
        for (int i = 0; i < 19; i++) begin
            if (sweep_code[i] == c) r = sweep_seg[i];
        end
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [39:0] act, input logic [39:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: invariant on every cycle, plus one scoreboard entry when present.
    initial begin
        forever begin
            @(negedge clk);
            if (inv_en) begin
                checks++;
                if ($isunknown(ifc.an) || $countones(~ifc.an) > 1) begin
                    errors++;
                    $display("FAIL an_onehot got %h want at most one low bit", ifc.an);
                end
            end
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                if (mon_e.c_an)  cmp({mon_e.name, " an"},  40'(ifc.an),         40'(mon_e.an));
                if (mon_e.c_seg) cmp({mon_e.name, " seg"}, 40'(ifc.seg),        40'(mon_e.seg));
                if (mon_e.c_num) cmp({mon_e.name, " num"}, 40'(ifc.num),        40'(mon_e.num));
                if (mon_e.c_lat) cmp({mon_e.name, " lat"}, ifc.dig_lat,         mon_e.lat);
                if (mon_e.c_ft)  cmp({mon_e.name, " ft"},  40'(ifc.frame_tick), 40'(mon_e.ft));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for cycle tc, counted from the first cycle after reset release.
    task automatic push_model();
        exp_t e;
        int dv, n, fr, ph;
        dv = tc % SD;
        n  = (tc / SD) % 8;
        fr = tc / (8 * SD);
        ph = (fr / BF) % 2;
        if (tc > 0 && tc % (8 * SD) == 0) exp_lat = ifc.dig;
        e.name  = $sformatf("%s@%0d", phase, tc);
        e.an    = 8'hFF;
        if (dv >= BC && ifc.en_mask[n] && !(ph == 1 && ifc.blink_mask[n])) e.an[n] = 1'b0;
        e.seg   = (tc == 0) ? 8'hFF : dec(prev_code);
        e.num   = 3'(n);
        e.lat   = exp_lat;
        e.ft    = (tc > 0 && tc % (8 * SD) == 0);
        e.c_an  = 1'b1;
        e.c_seg = 1'b1;
        e.c_num = 1'b1;
        e.c_lat = 1'b1;
        e.c_ft  = 1'b1;
        prev_code = exp_lat[5*n +: 5];
        q.push_back(e);
    endtask

    task automatic tick();
        step();
        tc++;
        push_model();
    endtask

    task automatic reset_hold(input int n);
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            inv_en = 1'b1;
            if (i < n - 1) begin
                e.name = $sformatf("%s_inrst%0d", phase, i);
                e.an = 8'hFF; e.seg = 8'hFF; e.num = 3'd0; e.lat = 40'd0; e.ft = 1'b0;
                e.c_an = 1'b1; e.c_seg = 1'b1; e.c_num = 1'b1; e.c_lat = 1'b1; e.c_ft = 1'b1;
                q.push_back(e);
            end
        end
        rst = 1'b0;
        tc = 0;
        exp_lat = 40'd0;
        prev_code = 5'd0;
        push_model();
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        sel_mode = 1'b1;
        code_drv = 5'd0;
        ifc.en_mask = 8'hFF;
        ifc.blink_mask = 8'h00;

        // Reset and plain scan with distinct digits.
        phase = "scan";
        ifc.dig = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        reset_hold(3);
        repeat (72) tick();

        // Frame latch: change dig mid-frame at num=3 of the second frame.
        phase = "latch";
        ifc.dig = {8{5'h08}};
        reset_hold(1);
        while (tc < 100) begin
            tick();
            if (tc == 44) ifc.dig = {8{5'h01}};
        end

        // Decode sweep with code driven directly.
        phase = "decode";
        sel_mode = 1'b0;
        reset_hold(1);
        code_drv = sweep_code[0];
        for (int i = 1; i <= 19; i++) begin
            step();
            e.name = $sformatf("decode_%0h", sweep_code[i-1]);
            e.seg = sweep_seg[i-1];
            e.c_seg = 1'b1;
            e.c_an = 1'b0; e.c_num = 1'b0; e.c_lat = 1'b0; e.c_ft = 1'b0;
            q.push_back(e);
            if (i < 19) code_drv = sweep_code[i];
        end

        // Mask and blink, with a one-cycle reset at num=5 div_cnt=2 while blink phase is 1.
        phase = "blink";
        sel_mode = 1'b1;
        ifc.en_mask = 8'h7F;
        ifc.blink_mask = 8'h01;
        ifc.dig = {8{5'h11}};
        reset_hold(1);
        while (tc < 86) tick();
        phase = "midrst";
        reset_hold(1);
        repeat (200) tick();

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the eight-digit seven-segment display of the vending machine front panel. It steps the digit index through 0–7 at a programmable rate and drives the digit-select input of the existing digit-code selector. It also frame-latches the 40-bit digit vector so a frame never tears, decodes the returned 5-bit code into segment patterns, and applies per-digit enable, blanking dead time and blink.

## Interface
- SCAN_DIV, 50000, clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYC, 1, dead-time cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYC < SCAN_DIV.
- BLINK_FRAMES, 64, full frames per blink half-period; legal range ≥ 1.
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- dig  input  40  five bits per digit; digit i is dig[5i+4:5i].
- en_mask  input  8  bit i=1 enables digit i; sampled live.
- blink_mask  input  8  bit i=1 makes digit i blink; sampled live.
- num  output  3  current digit index, fed to the selector.
- dig_lat  output  40  frame-latched copy of dig, fed to the selector.
- code  input  5  selector output for the current num.
- an  output  8  anode select, active low; at most one bit low.
- seg  output  8  {dp,g,f,e,d,c,b,a}, active low; dp always 1.
- frame_tick  output  1  one-cycle pulse on the cycle num wraps 7→0.

## Operation
- div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
- When div_cnt = SCAN_DIV-1, num increments on the next edge, wrapping 7→0.
- Frame latch: on the edge where num wraps 7→0, dig_lat ← dig and frame_tick = 1 for that cycle. dig_lat is otherwise constant.
- Blink: frame_cnt counts frames 0..BLINK_FRAMES-1. When it wraps, blink_ph toggles.
- Anode rule: an[num] = 0 iff all of the following hold; all other bits are 1:
  - div_cnt ≥ BLANK_CYC
  - en_mask[num] = 1
  - NOT (blink_ph = 1 AND blink_mask[num] = 1)
- Decode table, registered into seg:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, B→83, C→C6, D→A1, E→86, F→8E
  - 5'h10 → FF (blank), 5'h11 → BF (minus), 5'h12–5'h1F → FF
- Reset values: num=0, div_cnt=0, dig_lat=0, an=FF, seg=FF, frame_tick=0, frame_cnt=0, blink_ph=0.
- Reset mid-slot: all state returns to reset values on the next edge. The first slot after reset is digit 0 with a full blanking interval.

## Timing
- num, div_cnt, dig_lat, blink_ph and frame_tick are registers.
- an is registered but computed from next-state values, so an always matches the current div_cnt/num with no lag.
- seg(t) = decode(code(t-1)); one-cycle latency.
  - code settles in the cycle num changes.
  - seg is therefore correct from slot cycle 1 onward.
  - BLANK_CYC ≥ 1 hides the stale pattern.
- Digit slot period is SCAN_DIV cycles; frame period is 8·SCAN_DIV cycles; blink half-period is BLINK_FRAMES·8·SCAN_DIV cycles.
- A change on dig takes effect at the next frame boundary: 1 to 8·SCAN_DIV cycles later.
- A change on en_mask or blink_mask takes effect on the next cycle's an.
- Simultaneous frame wrap and blink toggle: both happen on the same edge. frame_tick still pulses.

## Test plan
Unless stated otherwise, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.

- Reset/scan: hold rst for 3 cycles, then release with en_mask=FF.
  - Required: an=FF and seg=FF during reset.
  - Required: num sequence 0,0,0,0,1,… changing every 4 cycles.
  - Required: an = FF,FE,FE,FE,FF,FD,… and frame_tick pulses every 32 cycles.
- Frame latch: dig all 5'h08. Mid-frame (num=3), change dig to all 5'h01.
  - Required: dig_lat and seg stay 80 until the 7→0 wrap.
  - Required: seg=F9 for every digit from the next frame on.
- Decode sweep: drive code 0–F, then 10, 11, 1F.
  - Required: seg matches the table one cycle later (C0…8E, FF, BF, FF).
- Mask/blink: en_mask=7F, blink_mask=01.
  - Required: an[7] is never 0.
  - Required: an[0] low in frames 0–1, high in frames 2–3, low again in frames 4–5.
- Reset mid-operation: assert rst for 1 cycle at num=5, div_cnt=2.
  - Required: next cycle num=0, div_cnt=0, an=FF, dig_lat=0, blink_ph=0.
- Invariant (all tests): an never has more than one 0 bit.
- Invariant (all tests): an = FF whenever div_cnt < BLANK_CYC.
